wb_arbiter_rr: RTL and testbench

- Synthesisable, parametrised N-master Wishbone classic bus arbiter and master-side multiplexer.
- Replaces the fixed two-master (accelerator/CPU) behavioural arbiter.
- Selects one master per bus tenure using fixed-priority or round-robin arbitration.
- Drives a single shared slave-side bus and routes ack/err/read data back to the owner only.
- Adds a slave-response watchdog that terminates hung cycles with an error.

---
 rtl/wb_arbiter_rr.sv | 158 +++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr.sv
// N-master Wishbone classic arbiter with fixed-priority or round-robin selection,
// owner-only response routing and a slave-response watchdog.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 23,
  parameter int DW          = 32,
  parameter int ARB_MODE    = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic [DW-1:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]      gnt_o,
  output logic                        timeout_o
);

  localparam int SW = DW / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] gnt_r;
  logic [NUM_MASTERS-1:0] gnt_nxt_s;
  logic [NUM_MASTERS-1:0] req_s;
  logic [IW-1:0]          last_r;
  logic [IW-1:0]          win_idx_s;
  logic                   hold_s;
  logic                   new_gnt_s;
  logic                   fire_s;

  function automatic logic [IW-1:0] pick_fixed(input logic [NUM_MASTERS-1:0] req);
    logic [IW-1:0] pick;
    pick = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) pick = IW'(i);
      else        pick = pick;
    end
    return pick;
  endfunction

  // Search upward from the slot after the last winner, wrapping around.
  function automatic logic [IW-1:0] pick_rr(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IW-1:0]          last);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last) + i) % NUM_MASTERS;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // A timed-out owner may not win the re-arbitration on the edge that releases it.
  assign req_s     = m_cyc_i & ~(gnt_r & {NUM_MASTERS{fire_s}});
  assign hold_s    = (|(gnt_r & m_cyc_i)) & ~fire_s;
  assign win_idx_s = (ARB_MODE == 0) ? pick_fixed(req_s) : pick_rr(req_s, last_r);

  // Next-grant selection: hold, re-arbitrate, or go idle.
  always_comb begin
    gnt_nxt_s = '0;
    new_gnt_s = 1'b0;
    if (hold_s) begin
      gnt_nxt_s = gnt_r;
      new_gnt_s = 1'b0;
    end else if (|req_s) begin
      gnt_nxt_s = NUM_MASTERS'(1) << win_idx_s;
      new_gnt_s = 1'b1;
    end else begin
      gnt_nxt_s = '0;
      new_gnt_s = 1'b0;
    end
  end

  // Grant and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_r  <= '0;
      last_r <= IW'(NUM_MASTERS - 1);
    end else begin
      gnt_r <= gnt_nxt_s;
      if (new_gnt_s) last_r <= win_idx_s;
      else           last_r <= last_r;
    end
  end

  // Owner-to-slave multiplexer; grant is one-hot so an AND-OR tree suffices.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      s_cyc_o = s_cyc_o | (m_cyc_i[k] & gnt_r[k]);
      s_stb_o = s_stb_o | (m_stb_i[k] & gnt_r[k]);
      s_we_o  = s_we_o  | (m_we_i[k]  & gnt_r[k]);
      s_sel_o = s_sel_o | (m_sel_i[k*SW +: SW] & {SW{gnt_r[k]}});
      s_adr_o = s_adr_o | (m_adr_i[k*AW +: AW] & {AW{gnt_r[k]}});
      s_dat_o = s_dat_o | (m_dat_i[k*DW +: DW] & {DW{gnt_r[k]}});
    end
  end

  assign m_ack_o   = {NUM_MASTERS{s_ack_i}} & gnt_r;
  assign m_err_o   = {NUM_MASTERS{s_err_i | fire_s}} & gnt_r;
  assign m_dat_o   = s_dat_i;
  assign gnt_o     = gnt_r;
  assign timeout_o = fire_s;

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_r;
      logic          busy_s;

      // A response in the firing cycle masks busy, so ack wins over the watchdog.
      assign busy_s = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
      assign fire_s = busy_s & (cnt_r == CW'(TIMEOUT - 1));

      // Wait-state counter for the current strobe.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_r <= '0;
        end else if (!busy_s || fire_s || (gnt_nxt_s != gnt_r)) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end else begin : g_no_wdog
      assign fire_s = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed scoreboard bench: a round-robin and a fixed-priority instance share
// one set of master and slave stimulus.
module tb_wb_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]      m_cyc;
  logic [N-1:0]      m_stb;
  logic [N-1:0]      m_we;
  logic [N*DW/8-1:0] m_sel;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic              s_ack;
  logic              s_err;
  logic [DW-1:0]     s_dat;

  logic [DW-1:0]   dat_rr, dat_fp, s_dat_rr, s_dat_fp;
  logic [N-1:0]    ack_rr, ack_fp, err_rr, err_fp, gnt_rr, gnt_fp;
  logic            s_cyc_rr, s_cyc_fp, s_stb_rr, s_stb_fp, s_we_rr, s_we_fp;
  logic            to_rr, to_fp;
  logic [DW/8-1:0] s_sel_rr, s_sel_fp;
  logic [AW-1:0]   s_adr_rr, s_adr_fp;

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter_rr #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .ARB_MODE(1), .TIMEOUT(TO)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(dat_rr), .m_ack_o(ack_rr), .m_err_o(err_rr),
    .s_cyc_o(s_cyc_rr), .s_stb_o(s_stb_rr), .s_we_o(s_we_rr), .s_sel_o(s_sel_rr),
    .s_adr_o(s_adr_rr), .s_dat_o(s_dat_rr),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat),
    .gnt_o(gnt_rr), .timeout_o(to_rr)
  );

  wb_arbiter_rr #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .ARB_MODE(0), .TIMEOUT(TO)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(dat_fp), .m_ack_o(ack_fp), .m_err_o(err_fp),
    .s_cyc_o(s_cyc_fp), .s_stb_o(s_stb_fp), .s_we_o(s_we_fp), .s_sel_o(s_sel_fp),
    .s_adr_o(s_adr_fp), .s_dat_o(s_dat_fp),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat),
    .gnt_o(gnt_fp), .timeout_o(to_fp)
  );

  task automatic put(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int k, input logic cyc, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc[k]             = cyc;
    m_stb[k]             = cyc;
    m_we[k]              = we;
    m_sel[k*4 +: 4]      = cyc ? 4'hF : 4'h0;
    m_adr[k*AW +: AW]    = adr;
    m_dat[k*DW +: DW]    = dat;
  endtask

  // Grant must be one-hot or idle on every cycle.
  always @(negedge clk) begin
    vectors++;
    assert ($onehot0(gnt_rr) && $onehot0(gnt_fp)) else begin
      miscompares++;
      $error("FAIL onehot0: gnt_rr=%b gnt_fp=%b, required one-hot or zero", gnt_rr, gnt_fp);
    end
  end

  initial begin
    #200000;
    $display("FAIL guard: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] e;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    s_ack = 1'b0; s_err = 1'b0; s_dat = '0;

    // Reset state, with master 1 already requesting a write.
    repeat (2) @(posedge clk);
    #2;
    drive(1, 1'b1, 1'b1, 23'h400008, 32'h00008000);
    s_ack = 1'b1;
    #1;
    put(64'h0); chk("rst_gnt", 64'(gnt_rr));
    put(64'h0); chk("rst_scyc", 64'(s_cyc_rr));
    put(64'h0); chk("rst_ack", 64'(ack_rr));
    put(64'h0); chk("rst_timeout", 64'(to_rr));
    s_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single master write.
    tick;
    put(64'h2);        chk("t1_gnt", 64'(gnt_rr));
    put(64'h2);        chk("t1_gnt_fp", 64'(gnt_fp));
    put(64'h400008);   chk("t1_adr", 64'(s_adr_rr));
    put(64'h00008000); chk("t1_dat", 64'(s_dat_rr));
    put(64'h1);        chk("t1_we", 64'(s_we_rr));
    s_dat = 32'hA5A55A5A;
    s_ack = 1'b1;
    #1;
    put(64'h2);        chk("t1_ack", 64'(ack_rr));
    put(64'hA5A55A5A); chk("t1_rdata", 64'(dat_rr));
    tick;
    drive(1, 1'b0, 1'b0, '0, '0);
    s_ack = 1'b0;
    tick;
    put(64'h0); chk("t1_idle", 64'(gnt_rr));

    // Masters 1 and 3 from idle; fixed priority takes 1, round-robin (last=1) takes 3.
    drive(1, 1'b1, 1'b0, 23'h000100, 32'h11111111);
    drive(3, 1'b1, 1'b0, 23'h000300, 32'h33333333);
    tick;
    put(64'h2);   chk("t2_fp_gnt", 64'(gnt_fp));
    put(64'h8);   chk("t2_rr_gnt", 64'(gnt_rr));
    put(64'h100); chk("t2_fp_adr", 64'(s_adr_fp));
    drive(1, 1'b0, 1'b0, '0, '0);
    tick;
    put(64'h8);   chk("t2_fp_handoff", 64'(gnt_fp));
    put(64'h300); chk("t2_fp_adr3", 64'(s_adr_fp));
    drive(3, 1'b0, 1'b0, '0, '0);
    tick;
    put(64'h0); chk("t2_idle", 64'(gnt_rr));

    // Round-robin fairness among masters 0..2, one beat per tenure.
    for (int j = 0; j < 3; j++) drive(j, 1'b1, 1'b0, 23'(j * 16), 32'(j));
    for (int i = 0; i < 6; i++) begin
      tick;
      e = 4'b0001 << (i % 3);
      put(64'(e)); chk("t3_gnt", 64'(gnt_rr));
      for (int j = 0; j < 3; j++) drive(j, 1'b1, 1'b0, 23'(j * 16), 32'(j));
      s_ack = 1'b1;
      #1;
      put(64'(e)); chk("t3_ack", 64'(ack_rr));
      tick;
      s_ack = 1'b0;
      drive(i % 3, 1'b0, 1'b0, '0, '0);
    end
    for (int j = 0; j < 3; j++) drive(j, 1'b0, 1'b0, '0, '0);
    tick;
    put(64'h0); chk("t3_idle", 64'(gnt_rr));

    // Bus lock: master 0 holds across 5 acked beats while master 1 waits.
    drive(0, 1'b1, 1'b1, 23'h000040, 32'hCAFE0000);
    drive(1, 1'b1, 1'b0, 23'h000080, 32'hBEEF0000);
    tick;
    put(64'h1); chk("t4_gnt", 64'(gnt_rr));
    for (int b = 0; b < 5; b++) begin
      s_ack = 1'b1;
      #1;
      put(64'h1); chk("t4_ack", 64'(ack_rr));
      tick;
      put(64'h1); chk("t4_hold", 64'(gnt_rr));
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    s_ack = 1'b0;
    tick;
    put(64'h2); chk("t4_handoff", 64'(gnt_rr));
    drive(1, 1'b0, 1'b0, '0, '0);
    tick;

    // Watchdog: master 0 never acked, master 1 pending.
    drive(0, 1'b1, 1'b0, 23'h000500, 32'h0);
    tick;
    put(64'h1); chk("t5_gnt", 64'(gnt_rr));
    drive(1, 1'b1, 1'b0, 23'h000600, 32'h0);
    for (int c = 1; c < 8; c++) begin
      put(64'h0); chk("t5_quiet", 64'(to_rr));
      tick;
    end
    put(64'h1); chk("t5_timeout", 64'(to_rr));
    put(64'h1); chk("t5_err", 64'(err_rr));
    put(64'h1); chk("t5_timeout_fp", 64'(to_fp));
    tick;
    put(64'h2); chk("t5_regrant", 64'(gnt_rr));
    put(64'h2); chk("t5_regrant_fp", 64'(gnt_fp));
    put(64'h0); chk("t5_pulse_end", 64'(to_rr));
    repeat (7) tick;
    s_ack = 1'b1;
    #1;
    put(64'h0); chk("t5_ack8_timeout", 64'(to_rr));
    put(64'h0); chk("t5_ack8_err", 64'(err_rr));
    put(64'h2); chk("t5_ack8_ack", 64'(ack_rr));
    tick;
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick;

    // Asynchronous reset in the middle of master 2's cycle.
    drive(2, 1'b1, 1'b1, 23'h000700, 32'h77777777);
    tick;
    put(64'h4); chk("t6_gnt", 64'(gnt_rr));
    #1;
    rst_n = 1'b0;
    #1;
    put(64'h0); chk("t6_rst_gnt", 64'(gnt_rr));
    put(64'h0); chk("t6_rst_scyc", 64'(s_cyc_rr));
    put(64'h0); chk("t6_rst_gnt_fp", 64'(gnt_fp));
    drive(0, 1'b1, 1'b0, 23'h000010, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    put(64'h1); chk("t6_tie_rr", 64'(gnt_rr));
    put(64'h1); chk("t6_tie_fp", 64'(gnt_fp));
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
